comp2bcd_seq: RTL and testbench

- Sequential, parametrised successor to the combinational complement-to-true-form converter in the calculator datapath.
- Takes a WIDTH-bit operand, either two's complement or unsigned, and produces three results: a sign-magnitude ("true form") word, a sign flag, and a DIGITS-digit packed BCD magnitude for the 7-segment display driver.
- Conversion is iterative (shift-add-3, one bit per clock) with a start/busy/done handshake.
- Sits between the ALU result register and the display/digit-select logic.

---
 rtl/comp2bcd_seq.sv | 143 ++++++++++++++
 tb/tb_comp2bcd_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/comp2bcd_seq.sv
// comp2bcd_seq
// Sequential complement-to-true-form converter. Takes a two's complement or
// unsigned operand and produces a sign-magnitude word, a sign flag and a
// packed BCD magnitude. The BCD conversion is iterative (shift-add-3, one
// operand bit per clock) behind a start/busy/done handshake.
module comp2bcd_seq #(
    parameter int WIDTH  = 18,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      datain,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [WIDTH-1:0]      sm_out,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  mag_ovf,
    output logic                  bcd_ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Shift-add-3 correction: every digit of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] acc);
        logic [BW-1:0] res;
        res = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

    logic [1:0]        state_r;
    logic [CW-1:0]     cnt_r;
    logic              neg_r;
    logic [WIDTH-1:0]  mag_r;       // magnitude kept intact for sm_out
    logic [WIDTH-1:0]  shift_r;     // magnitude consumed by the shifter
    logic [BW-1:0]     bcd_acc_r;
    logic              sticky_ovf_r;

    logic              neg_s;
    logic [WIDTH-1:0]  mag_s;
    logic [BW-1:0]     adj_s;

    // Operand decode: sign and absolute value, in WIDTH bits unsigned so the
    // most negative value maps to 2^(WIDTH-1).
    always_comb begin
        neg_s = signed_mode & datain[WIDTH-1];
        if (neg_s) begin
            mag_s = ~datain + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_s = datain;
        end
    end

    assign adj_s = add3_digits(bcd_acc_r);

    // Control FSM, shift-add-3 datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            neg_r        <= 1'b0;
            mag_r        <= {WIDTH{1'b0}};
            shift_r      <= {WIDTH{1'b0}};
            bcd_acc_r    <= {BW{1'b0}};
            sticky_ovf_r <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sign         <= 1'b0;
            sm_out       <= {WIDTH{1'b0}};
            bcd          <= {BW{1'b0}};
            mag_ovf      <= 1'b0;
            bcd_ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        neg_r        <= neg_s;
                        mag_r        <= mag_s;
                        shift_r      <= mag_s;
                        bcd_acc_r    <= {BW{1'b0}};
                        sticky_ovf_r <= 1'b0;
                        cnt_r        <= CNT_INIT;
                        busy         <= 1'b1;
                        state_r      <= ST_CONV;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    // Correct, then shift {bcd_acc, shift} left by one bit;
                    // whatever leaves the top digit means the value is too big.
                    bcd_acc_r    <= {adj_s[BW-2:0], shift_r[WIDTH-1]};
                    shift_r      <= {shift_r[WIDTH-2:0], 1'b0};
                    sticky_ovf_r <= sticky_ovf_r | adj_s[BW-1];
                    cnt_r        <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                ST_FIN: begin
                    sign    <= neg_r;
                    bcd     <= bcd_acc_r;
                    bcd_ovf <= sticky_ovf_r;
                    mag_ovf <= mag_r[WIDTH-1];
                    if (mag_r[WIDTH-1]) begin
                        sm_out <= {neg_r, {(WIDTH-1){1'b1}}};
                    end else begin
                        sm_out <= {neg_r, mag_r[WIDTH-2:0]};
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp2bcd_seq.sv
// Directed self-checking bench for comp2bcd_seq: a WIDTH=18/DIGITS=6 instance
// for the main function and a WIDTH=18/DIGITS=4 instance for BCD overflow.
module tb_comp2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start6;
    logic        start4;
    logic        signed_mode;
    logic [17:0] datain;

    logic        busy6, done6, sign6, mag_ovf6, bcd_ovf6;
    logic [17:0] sm_out6;
    logic [23:0] bcd6;

    logic        busy4, done4, sign4, mag_ovf4, bcd_ovf4;
    logic [17:0] sm_out4;
    logic [15:0] bcd4;

    int checks   = 0;
    int failures = 0;

    // per-conversion measurements
    int          lat;
    int          busy_cnt;
    int          done_cnt;
    logic [17:0] hold_sm;

    comp2bcd_seq #(.WIDTH(18), .DIGITS(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .signed_mode(signed_mode),
        .datain(datain), .busy(busy6), .done(done6), .sign(sign6),
        .sm_out(sm_out6), .bcd(bcd6), .mag_ovf(mag_ovf6), .bcd_ovf(bcd_ovf6)
    );

    comp2bcd_seq #(.WIDTH(18), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signed_mode),
        .datain(datain), .busy(busy4), .done(done4), .sign(sign4),
        .sm_out(sm_out4), .bcd(bcd4), .mag_ovf(mag_ovf4), .bcd_ovf(bcd_ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One conversion on the selected instance (sel=1 -> DIGITS=4). Runs a
    // fixed window of 24 edges after the start edge, counting latency, busy
    // cycles and done pulses. Optionally re-pulses start at cycle inj_cyc.
    task automatic conv(input bit sel, input logic sm, input logic [17:0] d,
                        input int inj_cyc, input logic [17:0] inj_d);
        logic b, dn;
        lat = 0; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        signed_mode = sm; datain = d;
        if (sel) start4 = 1'b1; else start6 = 1'b1;
        @(posedge clk);
        #1;
        b  = sel ? busy4 : busy6;
        dn = sel ? done4 : done6;
        if (b)  busy_cnt++;
        if (dn) done_cnt++;
        for (int e = 2; e <= 25; e++) begin
            @(negedge clk);
            if (e - 1 == inj_cyc) begin
                hold_sm = sel ? sm_out4 : sm_out6;
                datain = inj_d;
                if (sel) start4 = 1'b1; else start6 = 1'b1;
            end else begin
                start4 = 1'b0; start6 = 1'b0;
            end
            @(posedge clk);
            #1;
            b  = sel ? busy4 : busy6;
            dn = sel ? done4 : done6;
            if (b)  busy_cnt++;
            if (dn) begin
                done_cnt++;
                if (lat == 0) lat = e;
            end
        end
        start4 = 1'b0; start6 = 1'b0;
    endtask

    initial begin
        start6 = 1'b0; start4 = 1'b0; signed_mode = 1'b0; datain = 18'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    64'(busy6),    64'h0);
        chk("rst_done",    64'(done6),    64'h0);
        chk("rst_sm",      64'(sm_out6),  64'h0);
        chk("rst_bcd",     64'(bcd6),     64'h0);
        chk("rst_flags",   64'({sign6, mag_ovf6, bcd_ovf6}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // signed +16
        conv(1'b0, 1'b1, 18'd16, 0, 18'd0);
        chk("p16_latency", 64'(lat),      64'd20);
        chk("p16_busy",    64'(busy_cnt), 64'd19);
        chk("p16_donecnt", 64'(done_cnt), 64'd1);
        chk("p16_sign",    64'(sign6),    64'h0);
        chk("p16_bcd",     64'(bcd6),     64'h000016);
        chk("p16_sm",      64'(sm_out6),  64'h00010);
        chk("p16_flags",   64'({mag_ovf6, bcd_ovf6}), 64'h0);

        // signed -128, -16
        conv(1'b0, 1'b1, 18'h3FF80, 0, 18'd0);
        chk("m128_sign",   64'(sign6),    64'h1);
        chk("m128_bcd",    64'(bcd6),     64'h000128);
        chk("m128_sm",     64'(sm_out6),  64'h20080);
        conv(1'b0, 1'b1, 18'h3FFF0, 0, 18'd0);
        chk("m16_sign",    64'(sign6),    64'h1);
        chk("m16_bcd",     64'(bcd6),     64'h000016);
        chk("m16_sm",      64'(sm_out6),  64'h20010);

        // start while busy is ignored; outputs hold during conversion
        conv(1'b0, 1'b0, 18'd777, 5, 18'd555);
        chk("ign_hold_sm", 64'(hold_sm),  64'h20010);
        chk("ign_busy",    64'(busy_cnt), 64'd19);
        chk("ign_donecnt", 64'(done_cnt), 64'd1);
        chk("ign_bcd",     64'(bcd6),     64'h000777);
        chk("ign_sm",      64'(sm_out6),  64'h00309);

        // most negative signed value
        conv(1'b0, 1'b1, 18'h20000, 0, 18'd0);
        chk("mneg_sign",   64'(sign6),    64'h1);
        chk("mneg_bcd",    64'(bcd6),     64'h131072);
        chk("mneg_magovf", 64'(mag_ovf6), 64'h1);
        chk("mneg_sm",     64'(sm_out6),  64'h3FFFF);
        chk("mneg_bcdovf", 64'(bcd_ovf6), 64'h0);

        // unsigned all-ones
        conv(1'b0, 1'b0, 18'h3FFFF, 0, 18'd0);
        chk("uff_sign",    64'(sign6),    64'h0);
        chk("uff_bcd",     64'(bcd6),     64'h262143);
        chk("uff_magovf",  64'(mag_ovf6), 64'h1);
        chk("uff_sm",      64'(sm_out6),  64'h1FFFF);

        // zero
        conv(1'b0, 1'b1, 18'd0, 0, 18'd0);
        chk("zero_all",    64'({sign6, mag_ovf6, bcd_ovf6, sm_out6, bcd6}), 64'h0);

        // DIGITS=4 instance
        conv(1'b1, 1'b0, 18'd12345, 0, 18'd0);
        chk("d4_12345_ovf", 64'(bcd_ovf4), 64'h1);
        chk("d4_latency",   64'(lat),      64'd20);
        conv(1'b1, 1'b0, 18'd9999, 0, 18'd0);
        chk("d4_9999_bcd",  64'(bcd4),     64'h9999);
        chk("d4_9999_ovf",  64'(bcd_ovf4), 64'h0);

        // reset mid-conversion aborts; prior result (-16 style) must clear
        conv(1'b0, 1'b1, 18'h3FFF0, 0, 18'd0);
        @(negedge clk);
        signed_mode = 1'b0; datain = 18'd999; start6 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start6 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(busy6),   64'h0);
        chk("abort_outs",  64'({sign6, mag_ovf6, bcd_ovf6, sm_out6, bcd6}), 64'h0);
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 2) rst_n = 1'b1;
            @(posedge clk);
            #1;
            if (done6) done_cnt++;
            @(negedge clk);
        end
        chk("abort_nodone", 64'(done_cnt), 64'd0);

        conv(1'b0, 1'b1, 18'd128, 0, 18'd0);
        chk("post_bcd",    64'(bcd6),    64'h000128);
        chk("post_sm",     64'(sm_out6), 64'h00080);
        chk("post_lat",    64'(lat),     64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
